// File: rtl/prb_et_if.sv
// Operand-source / counter-consumer bundle for the early-termination sequencer.
// PRB_ET_ABORT_EN adds the abort request and aborted status.
interface prb_et_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0][W-1:0] Bxs;
  logic                cnt_valid;
  logic                cnt_ready;
  logic [W-1:0]        cnt;
  logic [W-1:0]        k_init;
  logic                done;
  logic [W:0]          cycles;
`ifdef PRB_ET_ABORT_EN
  logic                abort;
  logic                aborted;
`endif

  // Source / consumer side
  modport master (
    output in_valid, Bxs, cnt_ready,
`ifdef PRB_ET_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  in_ready, cnt_valid, cnt, k_init, done, cycles
  );

  // Sequencer side
  modport slave (
    input  in_valid, Bxs, cnt_ready,
`ifdef PRB_ET_ABORT_EN
    input  abort,
    output aborted,
`endif
    output in_ready, cnt_valid, cnt, k_init, done, cycles
  );
endinterface

// File: rtl/prb_et_ctrl.sv
// Early-termination sequencer around the prb skip-mask logic: steps the RNS counter only
// over bit positions some operand still needs. Optional abort support: PRB_ET_ABORT_EN.
module prb_et_ctrl #(
  parameter int unsigned W        = 8,
  parameter int unsigned N        = 2,
  parameter int unsigned S_GROUPS = 1,
  parameter int unsigned CORR     = 1
) (
  input  logic     clk,
  input  logic     rst,
  prb_et_if.slave  bus
);
  localparam int unsigned CW = W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                     state_q, state_d;

  logic [N-1:0][W-1:0]        bx_q, bx_d;
  logic [W-1:0]               mask_q, mask_d;
  logic [W-1:0]               cnt_q, cnt_d;
  logic [W-1:0]               k_init_q, k_init_d;
  logic [CW-1:0]              beat_q, beat_d;
  logic [CW-1:0]              cycles_q, cycles_d;
  logic                       in_ready_q, in_ready_d;
  logic                       cnt_valid_q, cnt_valid_d;
  logic                       done_q, done_d;
`ifdef PRB_ET_ABORT_EN
  logic                       aborted_q, aborted_d;
`endif

  logic [W-1:0]               bx_or;
  logic [S_GROUPS-1:0][W-1:0] skip;
  logic [W-1:0]               prb_mask;
  logic [W-1:0]               prb_k_init;
  logic [W-1:0]               hi_fill;
  logic [W-1:0]               cnt_nxt;
  logic                       accept;
  logic                       abort_hit;
  logic                       beat;
  logic                       last;

  // Set every bit at or below the highest set bit of x.
  function automatic logic [W-1:0] fill_dn(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = x;
    for (int i = 1; i < int'(W); i++) r = r | (x >> i);
    return r;
  endfunction

  // Set every bit at or above the lowest set bit of x.
  function automatic logic [W-1:0] fill_up(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = x;
    for (int i = 1; i < int'(W); i++) r = r | (x << i);
    return r;
  endfunction

  // prb: positions outside [lsb, msb] of an operand cannot change its comparison outcome.
  always_comb begin : prb
    bx_or = '0;
    for (int n = 0; n < int'(N); n++) bx_or = bx_or | bx_q[n];
    skip = '0;
    for (int g = 0; g < int'(S_GROUPS); g++) begin
      if (CORR != 0)       skip[g] = ~(fill_dn(bx_or) & fill_up(bx_or));
      else if (g < int'(N)) skip[g] = ~(fill_dn(bx_q[g]) & fill_up(bx_q[g]));
      else                 skip[g] = '1;
    end
    prb_mask = '1;
    for (int g = 0; g < int'(S_GROUPS); g++) prb_mask = prb_mask & skip[g];
    hi_fill    = fill_dn(bx_or);
    prb_k_init = hi_fill & ~(hi_fill >> 1);
  end

  // Packed count over free positions: force masked bits to 1 so the carry ripples through them.
  assign cnt_nxt = ((cnt_q | mask_q) + W'(1)) & ~mask_q;
  assign last    = (cnt_nxt == '0);
  assign accept  = (state_q == IDLE) && bus.in_valid;

`ifdef PRB_ET_ABORT_EN
  assign abort_hit = (state_q == RUN) && bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign beat = (state_q == RUN) && bus.cnt_ready && !abort_hit;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (abort_hit || (beat && last)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bx_d        = bx_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    k_init_d    = k_init_q;
    beat_d      = beat_q;
    cycles_d    = cycles_q;
    done_d      = 1'b0;
`ifdef PRB_ET_ABORT_EN
    aborted_d   = 1'b0;
`endif
    in_ready_d  = (state_d == IDLE);
    cnt_valid_d = (state_d == RUN);
    unique case (state_q)
      IDLE: if (accept) bx_d = bus.Bxs;
      LOAD: begin
        mask_d   = prb_mask;
        k_init_d = prb_k_init;
        cnt_d    = '0;
        beat_d   = '0;
      end
      RUN: begin
        if (abort_hit) begin
          done_d    = 1'b1;
          cycles_d  = beat_q;
          cnt_d     = '0;
`ifdef PRB_ET_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (beat) begin
          beat_d = beat_q + CW'(1);
          if (last) begin
            done_d   = 1'b1;
            cycles_d = beat_q + CW'(1);
            cnt_d    = '0;
          end else begin
            cnt_d    = cnt_nxt;
          end
        end
      end
      DONE:    cnt_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q        <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      k_init_q    <= '0;
      beat_q      <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_valid_q <= 1'b0;
`ifdef PRB_ET_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      bx_q        <= bx_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      k_init_q    <= k_init_d;
      beat_q      <= beat_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      cnt_valid_q <= cnt_valid_d;
`ifdef PRB_ET_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.cnt       = cnt_q;
  assign bus.k_init    = k_init_q;
  assign bus.done      = done_q;
  assign bus.cycles    = cycles_q;
`ifdef PRB_ET_ABORT_EN
  assign bus.aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_prb_et_ctrl.sv
// Directed scoreboard bench for prb_et_ctrl (W=8, N=2, S_GROUPS=1, CORR=1).
module tb_prb_et_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  prb_et_if #(.W(8), .N(2)) bus ();

  prb_et_ctrl #(.W(8), .N(2), .S_GROUPS(1), .CORR(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One job: model builds the expected beat list, then the DUT stream is checked against it.
  task automatic run_job(input logic [7:0] b1, input logic [7:0] b0,
                         input int stall_val, input int stall_len,
                         input int abort_val, input int rst_val,
                         input bit hold, input logic [7:0] h1, input logic [7:0] h0);
    logic [7:0] orv, mask, kexp, v;
    int         lo, hi, beats, exp_cycles, stall_left, cyc;
    int         free_pos[$];
    logic [7:0] exp_q[$];
    bit         exp_done, exp_ab, fin, rdy, ab, stalled;

    orv = b1 | b0; lo = -1; hi = -1;
    for (int i = 0; i < 8; i++) if (orv[i]) begin if (lo < 0) lo = i; hi = i; end
    mask = 8'hFF; kexp = 8'h00;
    if (hi >= 0) begin
      for (int i = lo; i <= hi; i++) mask[i] = 1'b0;
      kexp[hi] = 1'b1;
    end
    for (int i = 0; i < 8; i++) if (!mask[i]) free_pos.push_back(i);
    for (int n = 0; n < (1 << free_pos.size()); n++) begin
      v = '0;
      for (int j = 0; j < free_pos.size(); j++) v[free_pos[j]] = n[j];
      exp_q.push_back(v);
    end

    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.Bxs = {b1, b0}; bus.in_valid = 1'b1;
    @(negedge clk);
    check("load_in_ready", 32'(bus.in_ready), 32'd0);
    check("load_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    if (hold) bus.Bxs = {h1, h0}; else bus.in_valid = 1'b0;
    @(negedge clk);
    check("k_init", 32'(bus.k_init), 32'(kexp));

    beats = 0; exp_cycles = 0; exp_done = 0; exp_ab = 0; fin = 0;
    stall_left = stall_len; stalled = 0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (exp_done) begin
        check("done", 32'(bus.done), 32'd1);
        check("cycles", 32'(bus.cycles), 32'(exp_cycles));
        check("done_cnt_valid", 32'(bus.cnt_valid), 32'd0);
        check("done_cnt", 32'(bus.cnt), 32'd0);
`ifdef PRB_ET_ABORT_EN
        check("aborted", 32'(bus.aborted), 32'(exp_ab));
`endif
        bus.cnt_ready = 1'b0;
        @(negedge clk);
        check("post_done", 32'(bus.done), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_cnt", 32'(bus.cnt), 32'd0);
        fin = 1;
      end else begin
        check("run_done_low", 32'(bus.done), 32'd0);
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        check("run_cnt_valid", 32'(bus.cnt_valid), 32'd1);
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(bus.cnt_valid), 32'd0);
          fin = 1;
        end else begin
          check("cnt", 32'(bus.cnt), 32'(exp_q[0]));
          if (rst_val >= 0 && int'(bus.cnt) == rst_val) begin
            rst = 1'b1; bus.cnt_ready = 1'b1;
            @(negedge clk);
            rst = 1'b0; bus.cnt_ready = 1'b0;
            check("rst_in_ready", 32'(bus.in_ready), 32'd1);
            check("rst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_cnt", 32'(bus.cnt), 32'd0);
            @(negedge clk);
            check("rst_no_done", 32'(bus.done), 32'd0);
            exp_q.delete();
            fin = 1;
          end else begin
            rdy = 1'b1;
            if (stall_val >= 0 && int'(bus.cnt) == stall_val && stall_left > 0) begin
              rdy = 1'b0; stall_left--; stalled = 1;
            end
            ab = 1'b0;
`ifdef PRB_ET_ABORT_EN
            ab = (abort_val >= 0 && int'(bus.cnt) == abort_val);
            bus.abort = ab;
`endif
            bus.cnt_ready = rdy;
            if (ab) begin
              exp_done = 1; exp_ab = 1; exp_cycles = beats;
            end else if (rdy) begin
              void'(exp_q.pop_front());
              beats++;
              if (exp_q.size() == 0) begin exp_done = 1; exp_cycles = beats; end
            end
            @(negedge clk);
`ifdef PRB_ET_ABORT_EN
            bus.abort = 1'b0;
`endif
          end
        end
      end
    end
    bus.cnt_ready = 1'b0;
    if (!fin) check("timeout", 32'd0, 32'd1);
    if (stall_len > 0) check("stall_seen", 32'(stalled), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.Bxs = '0; bus.cnt_ready = 1'b0;
`ifdef PRB_ET_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_state_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_state_cnt_valid", 32'(bus.cnt_valid), 32'd0);
    check("rst_state_cnt", 32'(bus.cnt), 32'd0);
    check("rst_state_k_init", 32'(bus.k_init), 32'd0);
    check("rst_state_done", 32'(bus.done), 32'd0);
    check("rst_state_cycles", 32'(bus.cycles), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_job(8'h2C, 8'h08, -1, 0, -1, -1, 1'b0, 8'h00, 8'h00);
    check("t1_k_init", 32'(bus.k_init), 32'h20);
    check("t1_cycles", 32'(bus.cycles), 32'd16);
    run_job(8'h00, 8'h00, -1, 0, -1, -1, 1'b0, 8'h00, 8'h00);
    check("t2_cycles", 32'(bus.cycles), 32'd1);
    run_job(8'h81, 8'h00, -1, 0, -1, -1, 1'b0, 8'h00, 8'h00);
    check("t3_cycles", 32'(bus.cycles), 32'd256);
    run_job(8'h2C, 8'h08, 8'h10, 3, -1, -1, 1'b0, 8'h00, 8'h00);
    check("t4_cycles", 32'(bus.cycles), 32'd16);
    run_job(8'h50, 8'h0A, -1, 0, -1, -1, 1'b0, 8'h00, 8'h00);
    check("t_extra_cycles", 32'(bus.cycles), 32'd64);
    run_job(8'h2C, 8'h08, -1, 0, -1, 8'h08, 1'b0, 8'h00, 8'h00);
    run_job(8'h2C, 8'h08, -1, 0, -1, -1, 1'b0, 8'h00, 8'h00);
    check("t5_cycles", 32'(bus.cycles), 32'd16);
`ifdef PRB_ET_ABORT_EN
    run_job(8'h2C, 8'h08, -1, 0, 8'h0C, -1, 1'b1, 8'h00, 8'h00);
    check("t6_cycles", 32'(bus.cycles), 32'd3);
    run_job(8'h00, 8'h00, -1, 0, -1, -1, 1'b0, 8'h00, 8'h00);
    check("t6_next_cycles", 32'(bus.cycles), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
